// File: rtl/booth_mult_unit.sv
// booth_mult_unit: iterative radix-2 Booth signed multiplier.
// One Booth step per clock; WIDTH steps per multiply, then a one-cycle DONE.
// The accumulator is WIDTH+1 bits so that a multiplicand of -2^(WIDTH-1)
// can be negated without overflow; only its low WIDTH bits reach hi.
module booth_mult_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam int unsigned SW = 2 * WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH:0]   m_q;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] q_q;
    logic             q1_q;
    logic [CW-1:0]    count_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH:0]   acc_sum;
    logic [SW-1:0]    shift_in;
    logic [SW-1:0]    shift_out;
    logic [WIDTH:0]   acc_d;
    logic [WIDTH-1:0] q_d;
    logic             q1_d;

    // One Booth step: add/subtract M per {Q[0],Q_1}, then arithmetic shift {ACC,Q,Q_1}
    always_comb begin
        acc_sum = acc_q;
        case ({q_q[0], q1_q})
            2'b01:   acc_sum = acc_q + m_q;
            2'b10:   acc_sum = acc_q - m_q;
            default: acc_sum = acc_q;
        endcase
        shift_in  = {acc_sum, q_q, q1_q};
        shift_out = {shift_in[SW-1], shift_in[SW-1:1]};
        acc_d     = shift_out[SW-1:WIDTH+1];
        q_d       = shift_out[WIDTH:1];
        q1_d      = shift_out[0];
    end

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        m_q     <= {a[WIDTH-1], a};
                        acc_q   <= '0;
                        q_q     <= b;
                        q1_q    <= 1'b0;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    q_q     <= q_d;
                    q1_q    <= q1_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST) begin
                        hi_q    <= acc_d[WIDTH-1:0];
                        lo_q    <= q_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        m_q     <= {a[WIDTH-1], a};
                        acc_q   <= '0;
                        q_q     <= b;
                        q1_q    <= 1'b0;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_booth_mult_unit.sv
// Scoreboard bench for booth_mult_unit: accepted starts push the expected
// product and done-cycle; a negedge monitor pops and compares on each done.
module tb_booth_mult_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    booth_mult_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    typedef struct {
        logic [63:0] prod;
        int          due;
        logic [31:0] ea;
        logic [31:0] eb;
    } exp_t;

    exp_t        sb[$];
    int          total;
    int          bad;
    int          cyc;
    bit          mon_en;
    logic [63:0] last_res;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: exact signed 64-bit product
    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
    endfunction

    // Monitor: compares results on done, hold behaviour otherwise
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 64'(cyc), 64'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("product", {hi, lo}, e.prod);
                    chk("done_latency", 64'(cyc), 64'(e.due));
                    chk("busy_in_done", {63'd0, busy}, 64'd0);
                    last_res = e.prod;
                end
            end else begin
                chk("hold_hilo", {hi, lo}, last_res);
            end
        end
    end

    task automatic issue(input logic [31:0] av, input logic [31:0] bv);
        exp_t e;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        e.prod = ref_mul(av, bv); e.due = cyc + 32; e.ea = av; e.eb = bv;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        exp_t e;
        total = 0; bad = 0; cyc = 0; mon_en = 0; last_res = '0;
        reset = 1'b0; start = 1'b0; a = '0; b = '0;
        #3;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        #19 reset = 1'b1;
        mon_en = 1;

        // Directed products including boundary operands
        issue(32'd3, 32'd4);                 drain();
        issue(32'hFFFF_FFFE, 32'd3);         drain();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF); drain();
        issue(32'h8000_0000, 32'h8000_0000); drain();
        issue(32'h8000_0000, 32'd1);         drain();
        issue(32'd0, 32'h8000_0000);         drain();

        // Random products
        for (int i = 0; i < 16; i++) begin
            issue(pick(), pick());
            drain();
        end

        // start during RUN is ignored; busy remains high
        issue(32'd12345, 32'hFFFF_FD5A);
        repeat (4) @(negedge clk);
        a = 32'd99; b = 32'd77; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignored_start", {63'd0, busy}, 64'd1);
        drain();
        repeat (5) @(negedge clk);

        // Reset mid-operation aborts with no done pulse
        issue(32'd1000, 32'd2000);
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        sb.delete();
        last_res = '0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        repeat (40) @(negedge clk);
        issue(32'd7, 32'd6);
        drain();

        // Back-to-back: start held through the DONE cycle
        @(negedge clk);
        a = 32'hDEAD_BEEF; b = 32'h1234_5678; start = 1'b1;
        @(posedge clk); #1;
        e.prod = ref_mul(32'hDEAD_BEEF, 32'h1234_5678); e.due = cyc + 32;
        e.ea = 32'hDEAD_BEEF; e.eb = 32'h1234_5678;
        sb.push_back(e);
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (done) seen = 1;
            end
            chk("b2b_first_done_seen", {63'd0, seen}, 64'd1);
        end
        a = 32'hFFFF_FF85; b = 32'h0000_0101;
        @(posedge clk); #1;
        e.prod = ref_mul(32'hFFFF_FF85, 32'h0000_0101); e.due = cyc + 32;
        e.ea = 32'hFFFF_FF85; e.eb = 32'h0000_0101;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        a = $urandom; b = $urandom;
        drain();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/booth_mult_unit.md
BOOTH_MULT_UNIT -- requirements
Module: booth_mult_unit

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-low, named reset.
REQ-002 Parameter WIDTH SHALL default to 32 and set the operand width; all values below assume WIDTH=32.
REQ-003 Port clk SHALL be an input, 1 bit wide: the system clock; all state updates occur on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit wide, active-low and asynchronous: it clears all state.
REQ-005 Port start SHALL be an input, 1 bit wide: a request to begin a multiply, sampled at the rising clk edge.
REQ-006 Port a SHALL be an input, WIDTH bits wide: the signed multiplicand, from the A register.
REQ-007 Port b SHALL be an input, WIDTH bits wide: the signed multiplier, from the B register.
REQ-008 Port busy SHALL be an output, 1 bit wide: high while an operation is iterating.
REQ-009 Port done SHALL be an output, 1 bit wide: a one-cycle completion pulse that qualifies HiLo_load.
REQ-010 Port hi SHALL be an output, WIDTH bits wide: the upper half of the product, feeding the Hi select mux.
REQ-011 Port lo SHALL be an output, WIDTH bits wide: the lower half of the product, feeding the Lo select mux.

Function
REQ-012 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE, start=1 at an edge SHALL capture the operands and go to RUN. Capture is M <= sign-extend(a) to WIDTH+1 bits, ACC <= 0 (WIDTH+1 bits), Q <= b, Q_1 <= 0, count <= 0.
REQ-014 In RUN, each edge SHALL perform one radix-2 Booth step on {Q[0],Q_1}:
- 01: ACC+M
- 10: ACC-M
- 00 or 11: ACC unchanged
After that, {ACC,Q,Q_1} SHALL be arithmetic-shifted right by 1, and count SHALL increment.
REQ-015 ACC SHALL be WIDTH+1 bits so that M = -2^(WIDTH-1) does not overflow; the extra bit SHALL never appear on hi or lo.
REQ-016 On the edge performing iteration WIDTH (count = WIDTH-1), the block SHALL:
- load hi <= ACC[WIDTH-1:0] and lo <= Q from the post-shift values;
- go to DONE.
REQ-017 Latency: done SHALL be high in the cycle beginning exactly WIDTH (32) edges after the edge that sampled start.
REQ-018 done SHALL be 1 only in DONE, for exactly one cycle.
REQ-019 busy SHALL be 1 only in RUN.
REQ-020 From DONE, the next state SHALL be RUN if start=1, capturing the operands as in REQ-013, else IDLE.
REQ-021 start while in RUN SHALL be ignored: no restart and no operand recapture.
REQ-022 hi and lo SHALL change only at completion, hold their value through IDLE and any later RUN, and never show intermediate partial products.
REQ-023 The product SHALL equal the exact two's-complement signed 2*WIDTH-bit result {hi,lo} = a*b for all operand pairs, including 0, -1 and -2^31.
REQ-024 Changes on a and b after the start edge SHALL NOT affect the result.

Reset
REQ-025 Asserting reset (low) SHALL immediately, without waiting for clk:
- force state to IDLE;
- clear busy, done, hi, lo, ACC, Q, Q_1, M and count to 0.
REQ-026 reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow for that operation.
REQ-027 After reset deasserts, the first start SHALL be accepted at the next rising edge.

Verification
REQ-028 Basic multiply: a=3, b=4, start pulse -> done exactly 32 cycles later, hi=0x00000000, lo=0x0000000C.
REQ-029 Mixed signs: a=0xFFFFFFFE (-2), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; a=b=0xFFFFFFFF -> hi=0, lo=1.
REQ-030 Boundary: a=b=0x80000000 -> hi=0x40000000, lo=0x00000000; a=0x80000000, b=1 -> hi=0xFFFFFFFF, lo=0x80000000.
REQ-031 Ignored start: start=1 at cycle 5 of RUN with new operands -> original product returned, busy stays high, a single done pulse.
REQ-032 Reset mid-operation: reset low at cycle 10 of RUN -> busy=done=hi=lo=0 at once, no done pulse afterwards; a following start with 7*6 -> lo=42 after 32 cycles.
REQ-033 Back-to-back: start held high through the DONE cycle -> the second operation begins; done pulses every 33 cycles; hi/lo hold the previous result until the second done.
